// File: rtl/flash_bus_arbiter.sv
// Round-robin arbiter and strobe sequencer for the shared external flash bus.
// One requester is granted at a time. Its request is run as a setup/access/hold
// strobe sequence, and completion is signalled with a one-cycle ack.
module flash_bus_arbiter #(
  parameter int unsigned NUM_MASTERS   = 2,
  parameter int unsigned ADDR_WIDTH    = 25,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned ACCESS_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES   = 2
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]            m_gnt,
  output logic [ADDR_WIDTH-1:0]             fsa,
  output logic [DATA_WIDTH-1:0]             fsd_o,
  output logic                              fsd_oe,
  input  logic [DATA_WIDTH-1:0]             fsd_i,
  output logic                              flash_ce_n,
  output logic                              flash_oe_n,
  output logic                              flash_we_n
);

  localparam int unsigned IdxW = $clog2(NUM_MASTERS);

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StHold, StDone} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [IdxW-1:0]        winner;
  logic                   found;
  int unsigned            cand;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [DATA_WIDTH-1:0]  wdata_d;
  logic [NUM_MASTERS-1:0] sel_vec;
  logic                   bus_active_d;

  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign addr_arr[g]  = m_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = m_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting one past the last winner
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    cand   = 0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = (32'(ptr_q) + k) % NUM_MASTERS;
      if (!found && m_req[cand[IdxW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IdxW-1:0];
      end
    end
  end

  // Next-state logic: phase sequencing and request latching on grant
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    addr_d  = fsa;
    wdata_d = fsd_o;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StSetup;
          cnt_d   = 4'(SETUP_CYCLES);
          ptr_d   = winner;
          we_d    = m_we[winner];
          addr_d  = addr_arr[winner];
          wdata_d = wdata_arr[winner];
        end
      end
      StSetup: begin
        if (cnt_q == 4'd1) begin
          state_d = StAccess;
          cnt_d   = 4'(ACCESS_CYCLES);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd1) begin
          state_d = StHold;
          cnt_d   = 4'(HOLD_CYCLES);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (cnt_q == 4'd1) begin
          state_d = StDone;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // One-hot of the granted master and the bus-driving phases of the next state
  always_comb begin
    sel_vec        = '0;
    sel_vec[ptr_d] = 1'b1;
    bus_active_d   = (state_d == StSetup) || (state_d == StAccess) || (state_d == StHold);
  end

  // State and registered outputs; outputs are computed from the next state so they line up
  // with the phase they belong to
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      ptr_q      <= IdxW'(NUM_MASTERS - 1);
      we_q       <= 1'b0;
      fsa        <= '0;
      fsd_o      <= '0;
      fsd_oe     <= 1'b0;
      m_gnt      <= '0;
      m_ack      <= '0;
      m_rdata    <= '0;
      flash_ce_n <= 1'b1;
      flash_oe_n <= 1'b1;
      flash_we_n <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      we_q       <= we_d;
      fsa        <= addr_d;
      fsd_o      <= wdata_d;
      m_gnt      <= (state_d != StIdle) ? sel_vec : '0;
      m_ack      <= (state_d == StDone) ? sel_vec : '0;
      flash_ce_n <= !bus_active_d;
      flash_oe_n <= !((state_d == StAccess) && !we_d);
      flash_we_n <= !((state_d == StAccess) && we_d);
      // Only writes drive the data pins, and never in DONE, so the bus turns around before IDLE
      fsd_oe     <= bus_active_d && we_d;
      if ((state_q == StAccess) && (cnt_q == 4'd1) && !we_q) begin
        m_rdata <= fsd_i;
      end
    end
  end

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Bench for flash_bus_arbiter: a default-timing instance (a) and a 1/1/1 timing instance (b)
// share all inputs. A transaction-level model predicts every output of both on every cycle.
module tb_flash_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 25;
  localparam int DW = 16;

  int sp [2] = '{2, 1};
  int ap [2] = '{8, 1};
  int hp [2] = '{2, 1};

  logic            clk;
  logic            resetn;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0]   fsd_i;

  logic [N-1:0]    ack_o   [2];
  logic [N-1:0]    gnt_o   [2];
  logic [DW-1:0]   rdata_o [2];
  logic [DW-1:0]   fsdo_o  [2];
  logic [AW-1:0]   fsa_o   [2];
  logic            oe_o    [2];
  logic            ce_o    [2];
  logic            oen_o   [2];
  logic            wen_o   [2];

  int checks = 0;
  int errors = 0;

  flash_bus_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SETUP_CYCLES(2), .ACCESS_CYCLES(8), .HOLD_CYCLES(2)
  ) u_dut_a (
    .clk(clk), .resetn(resetn), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(ack_o[0]), .m_rdata(rdata_o[0]), .m_gnt(gnt_o[0]),
    .fsa(fsa_o[0]), .fsd_o(fsdo_o[0]), .fsd_oe(oe_o[0]), .fsd_i(fsd_i),
    .flash_ce_n(ce_o[0]), .flash_oe_n(oen_o[0]), .flash_we_n(wen_o[0])
  );

  flash_bus_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SETUP_CYCLES(1), .ACCESS_CYCLES(1), .HOLD_CYCLES(1)
  ) u_dut_b (
    .clk(clk), .resetn(resetn), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(ack_o[1]), .m_rdata(rdata_o[1]), .m_gnt(gnt_o[1]),
    .fsa(fsa_o[1]), .fsd_o(fsdo_o[1]), .fsd_oe(oe_o[1]), .fsd_i(fsd_i),
    .flash_ce_n(ce_o[1]), .flash_oe_n(oen_o[1]), .flash_we_n(wen_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: per instance, busy flag and cycle index t within the transaction
  // (1..SETUP+ACCESS+HOLD+1, the last being the ack cycle)
  int            mdl_busy [2] = '{0, 0};
  int            mdl_t    [2] = '{0, 0};
  int            mdl_win  [2] = '{0, 0};
  int            mdl_ptr  [2] = '{N - 1, N - 1};
  logic          mdl_we   [2] = '{1'b0, 1'b0};
  logic [AW-1:0] mdl_addr [2] = '{'0, '0};
  logic [DW-1:0] mdl_wd   [2] = '{'0, '0};
  logic [DW-1:0] mdl_rd   [2] = '{'0, '0};

  function automatic int pick(input int ptr, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic int lat(input int i);
    return sp[i] + ap[i] + hp[i] + 1;
  endfunction

  function automatic bit in_act(input int i);
    return mdl_busy[i] != 0 && mdl_t[i] < lat(i);
  endfunction

  function automatic bit in_acc(input int i);
    return mdl_busy[i] != 0 && mdl_t[i] > sp[i] && mdl_t[i] <= sp[i] + ap[i];
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge resetn) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        mdl_busy[i] <= 0;
        mdl_t[i]    <= 0;
        mdl_ptr[i]  <= N - 1;
        mdl_rd[i]   <= '0;
      end else if (mdl_busy[i] == 0) begin
        if (m_req != '0) begin
          mdl_busy[i] <= 1;
          mdl_t[i]    <= 1;
          mdl_win[i]  <= pick(mdl_ptr[i], m_req);
          mdl_ptr[i]  <= pick(mdl_ptr[i], m_req);
          mdl_we[i]   <= m_we[pick(mdl_ptr[i], m_req)];
          mdl_addr[i] <= m_addr[pick(mdl_ptr[i], m_req)*AW +: AW];
          mdl_wd[i]   <= m_wdata[pick(mdl_ptr[i], m_req)*DW +: DW];
        end
      end else begin
        if (mdl_t[i] == sp[i] + ap[i] && !mdl_we[i]) mdl_rd[i] <= fsd_i;
        if (mdl_t[i] == lat(i)) mdl_busy[i] <= 0;
        else mdl_t[i] <= mdl_t[i] + 1;
      end
    end
  end

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      string pre;
      pre = (i == 0) ? "a." : "b.";
      check({pre, "gnt"}, 64'(gnt_o[i]), (mdl_busy[i] != 0) ? 64'(onehot(mdl_win[i])) : 64'd0);
      check({pre, "ack"}, 64'(ack_o[i]),
            (mdl_busy[i] != 0 && mdl_t[i] == lat(i)) ? 64'(onehot(mdl_win[i])) : 64'd0);
      check({pre, "ce_n"}, 64'(ce_o[i]), 64'(!in_act(i)));
      check({pre, "oe_n"}, 64'(oen_o[i]), 64'(!(in_acc(i) && !mdl_we[i])));
      check({pre, "we_n"}, 64'(wen_o[i]), 64'(!(in_acc(i) && mdl_we[i])));
      check({pre, "fsd_oe"}, 64'(oe_o[i]), 64'(in_act(i) && mdl_we[i]));
      check({pre, "rdata"}, 64'(rdata_o[i]), 64'(mdl_rd[i]));
      if (mdl_busy[i] != 0) check({pre, "fsa"}, 64'(fsa_o[i]), 64'(mdl_addr[i]));
      if (mdl_busy[i] != 0 && mdl_we[i]) check({pre, "fsd_o"}, 64'(fsdo_o[i]), 64'(mdl_wd[i]));
    end
  end

  // Per-transaction observations on instance a (and b's first ack) for literal checks
  int            cnt_oen, cnt_wen, cnt_oe, b_ack_cyc, b_oen;
  logic [AW-1:0] fsa_c1, fsa_late;
  logic [DW-1:0] fsdo_c1, rd_at_ack;

  task automatic start_txn(input int m, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    @(posedge clk);
    #2;
    m_req[m]              = 1'b1;
    m_we[m]               = we;
    m_addr[m*AW +: AW]    = addr;
    m_wdata[m*DW +: DW]   = wd;
    fsd_i                 = rd;
  endtask

  // Cycle 1 is the cycle after the edge that samples the request
  task automatic watch(input logic [N-1:0] mask, input bit drop, input int chg_cyc,
                       output int ack_cyc, output int who);
    ack_cyc   = 0;
    who       = -1;
    cnt_oen   = 0;
    cnt_wen   = 0;
    cnt_oe    = 0;
    b_ack_cyc = 0;
    b_oen     = 0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40 && ack_cyc == 0; cyc++) begin
      @(negedge clk);
      if (!oen_o[0]) cnt_oen++;
      if (!wen_o[0]) cnt_wen++;
      if (oe_o[0]) cnt_oe++;
      if (cyc == 1) begin
        fsa_c1  = fsa_o[0];
        fsdo_c1 = fsdo_o[0];
      end
      if (cyc == chg_cyc) m_addr = ~m_addr;
      if (cyc == chg_cyc + 1) fsa_late = fsa_o[0];
      if (b_ack_cyc == 0) begin
        if (!oen_o[1]) b_oen++;
        if (ack_o[1] != '0) b_ack_cyc = cyc;
      end
      if ((ack_o[0] & mask) != '0) begin
        ack_cyc   = cyc;
        rd_at_ack = rdata_o[0];
        who       = ack_o[0][0] ? 0 : 1;
        if (drop) m_req[who] = 1'b0;
      end
    end
    if (ack_cyc == 0) check("ack_timeout", 64'(ack_cyc), 64'd1);
  endtask

  int ack_cyc, who;
  int seq [4];

  initial begin
    resetn  = 1'b1;
    m_req   = '0;
    m_we    = '0;
    m_addr  = '0;
    m_wdata = '0;
    fsd_i   = '0;
    #3 resetn = 1'b0;
    @(negedge clk);
    check("rst.fsa", 64'(fsa_o[0]), 64'd0);
    check("rst.gnt", 64'(gnt_o[0]), 64'd0);
    check("rst.ce_n", 64'(ce_o[0]), 64'd1);
    check("rst.fsd_oe", 64'(oe_o[0]), 64'd0);
    check("rst.rdata", 64'(rdata_o[0]), 64'd0);
    @(posedge clk);
    #2 resetn = 1'b1;

    // Read from master 0; instance b runs the same request with 1/1/1 timing
    start_txn(0, 1'b0, 25'h0000123, 16'h0000, 16'hBEEF);
    watch(2'b01, 1'b1, 0, ack_cyc, who);
    check("t1.ack_cyc", 64'(ack_cyc), 64'd13);
    check("t1.who", 64'(who), 64'd0);
    check("t1.oe_low", 64'(cnt_oen), 64'd8);
    check("t1.rdata", 64'(rd_at_ack), 64'hBEEF);
    check("t1.fsa", 64'(fsa_c1), 64'h0000123);
    check("t5.b_ack_cyc", 64'(b_ack_cyc), 64'd4);
    check("t5.b_oe_low", 64'(b_oen), 64'd1);

    // Write from master 1 at the top address
    start_txn(1, 1'b1, 25'h1FFFFFF, 16'h5A5A, 16'hDEAD);
    watch(2'b10, 1'b1, 0, ack_cyc, who);
    check("t2.ack_cyc", 64'(ack_cyc), 64'd13);
    check("t2.who", 64'(who), 64'd1);
    check("t2.we_low", 64'(cnt_wen), 64'd8);
    check("t2.oe_low", 64'(cnt_oen), 64'd0);
    check("t2.fsd_oe_hi", 64'(cnt_oe), 64'd12);
    check("t2.fsd_o", 64'(fsdo_c1), 64'h5A5A);
    check("t2.fsa", 64'(fsa_c1), 64'h1FFFFFF);
    check("t2.rdata_kept", 64'(rd_at_ack), 64'hBEEF);

    // Address changed mid-ACCESS must not reach the pins
    start_txn(0, 1'b0, 25'h00AAAAA, 16'h0000, 16'h3C3C);
    watch(2'b01, 1'b1, 6, ack_cyc, who);
    check("t6.fsa_frozen", 64'(fsa_late), 64'h00AAAAA);
    check("t6.rdata", 64'(rd_at_ack), 64'h3C3C);

    // Reset during ACCESS cycle 4, request kept pending
    start_txn(0, 1'b0, 25'h0000456, 16'h0000, 16'h1234);
    @(posedge clk);
    repeat (6) @(negedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    check("t4.ce_n", 64'(ce_o[0]), 64'd1);
    check("t4.oe_n", 64'(oen_o[0]), 64'd1);
    check("t4.fsd_oe", 64'(oe_o[0]), 64'd0);
    check("t4.ack", 64'(ack_o[0]), 64'd0);
    check("t4.rdata", 64'(rdata_o[0]), 64'd0);
    @(posedge clk);
    #2 resetn = 1'b1;
    watch(2'b01, 1'b1, 0, ack_cyc, who);
    check("t4.restart_ack", 64'(ack_cyc), 64'd13);
    check("t4.restart_rd", 64'(rd_at_ack), 64'h1234);

    // Contention from reset: both masters held high
    @(posedge clk);
    #2 resetn = 1'b0;
    m_req   = 2'b11;
    m_we    = 2'b00;
    m_addr  = {25'h0000222, 25'h0000111};
    fsd_i   = 16'h0F0F;
    @(posedge clk);
    #2 resetn = 1'b1;
    for (int j = 0; j < 4; j++) begin
      watch(2'b11, 1'b0, 0, ack_cyc, who);
      seq[j] = who;
    end
    m_req = '0;
    check("t3.grant0", 64'(seq[0]), 64'd0);
    check("t3.grant1", 64'(seq[1]), 64'd1);
    check("t3.grant2", 64'(seq[2]), 64'd0);
    check("t3.grant3", 64'(seq[3]), 64'd1);

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
